// File: rtl/ltl_cluster_monitor_agg.sv
// Per-cluster LTL violation aggregator: tap OR-reduction, sticky flags, saturating counters, record queue.
// Optional timestamping is enabled by defining LTL_AGG_TSTAMP_EN.
module ltl_cluster_monitor_agg #(
    parameter int NUM_PROP   = 10,
    parameter int NUM_TAP    = 4,
    parameter int CNT_W      = 16,
    parameter int TS_W       = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int ID_W      = (NUM_PROP > 1) ? $clog2(NUM_PROP) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic [NUM_PROP*NUM_TAP-1:0]  taps,
    input  logic [NUM_PROP-1:0]          clr_mask,
    output logic [NUM_PROP-1:0]          viol,
    output logic [NUM_PROP-1:0]          sticky,
    output logic                         any_viol,
    output logic [NUM_PROP*CNT_W-1:0]    cnt,
    output logic                         rec_valid,
    input  logic                         rec_ready,
    output logic [ID_W-1:0]              rec_id,
    output logic [TS_W-1:0]              rec_tstamp
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NUM_PROP-1:0] hit;
    logic [NUM_PROP-1:0] rise;
    logic [NUM_PROP-1:0] pend;
    logic [NUM_PROP-1:0] take;
    logic [CNT_W-1:0]    cnt_q [NUM_PROP];
    logic [ID_W-1:0]     sel;
    logic                found;
    logic                push;
    logic                pop;
    logic                full;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic [ID_W-1:0]     fifo_id [FIFO_DEPTH];

    always_comb begin
        hit = '0;
        for (int unsigned p = 0; p < NUM_PROP; p++) begin
            hit[p] = run & (|taps[p*NUM_TAP +: NUM_TAP]);
        end
    end

    assign rise     = hit & ~viol;
    assign any_viol = |viol;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            viol   <= '0;
            sticky <= '0;
            for (int unsigned p = 0; p < NUM_PROP; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            viol <= hit;
            for (int unsigned p = 0; p < NUM_PROP; p++) begin
                if (hit[p]) begin
                    sticky[p] <= 1'b1;
                end else if (clr_mask[p]) begin
                    sticky[p] <= 1'b0;
                end
                // A clear coinciding with a hit counts that hit
                if (clr_mask[p]) begin
                    cnt_q[p] <= hit[p] ? CNT_W'(1) : '0;
                end else if (hit[p] && (cnt_q[p] != '1)) begin
                    cnt_q[p] <= cnt_q[p] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int unsigned p = 0; p < NUM_PROP; p++) begin
            cnt[p*CNT_W +: CNT_W] = cnt_q[p];
        end
    end

    // Fixed priority: lowest pending property index wins
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned p = 0; p < NUM_PROP; p++) begin
            if (pend[p] && !found) begin
                sel   = ID_W'(p);
                found = 1'b1;
            end
        end
    end

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign rec_valid = (count != '0);
    assign pop       = rec_valid & rec_ready;
    assign push      = found & (~full | pop);

    always_comb begin
        take = '0;
        for (int unsigned p = 0; p < NUM_PROP; p++) begin
            take[p] = push & (sel == ID_W'(p));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PROP; p++) begin
                if (rise[p]) begin
                    pend[p] <= 1'b1;
                end else if (take[p]) begin
                    pend[p] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr] <= sel;
        end
    end

    // Storage is not reset; outputs are gated so an empty queue reads as zero
    assign rec_id = rec_valid ? fifo_id[rd_ptr] : '0;

`ifdef LTL_AGG_TSTAMP_EN
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] pend_ts [NUM_PROP];
    logic [TS_W-1:0] fifo_ts [FIFO_DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts <= '0;
            for (int unsigned p = 0; p < NUM_PROP; p++) begin
                pend_ts[p] <= '0;
            end
        end else begin
            if (run) begin
                ts <= ts + TS_W'(1);
            end
            // Coalesced rises keep the older stamp unless the slot drains this cycle
            for (int unsigned p = 0; p < NUM_PROP; p++) begin
                if (rise[p] && (!pend[p] || take[p])) begin
                    pend_ts[p] <= ts;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_ts[wr_ptr] <= pend_ts[sel];
        end
    end

    assign rec_tstamp = rec_valid ? fifo_ts[rd_ptr] : '0;
`else
    assign rec_tstamp = '0;
`endif

endmodule

// File: doc/ltl_cluster_monitor_agg.md
# ltl_cluster_monitor_agg

Parametrised violation aggregator for one LTL monitor cluster. Sits between a cluster's automata stage and the core-level monitor interface. It OR-reduces the automata report taps of each property into one registered violation line per property, keeps sticky flags and saturating hit counters, and queues one timestamped violation record per new violation onto a valid/ready stream. It supersedes the fixed 10-property, fixed-tap cluster top wrappers.

## Interface
Parameters:
- NUM_PROP, 10: properties in the cluster (1..64)
- NUM_TAP, 4: report taps per property (1..16)
- CNT_W, 16: per-property hit counter width
- TS_W, 32: timestamp width
- FIFO_DEPTH, 4: record queue depth (power of two, ≥2)
- ID_W, derived: $clog2(NUM_PROP), minimum 1

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  monitoring enable; low = taps ignored, counters and timestamp frozen
- taps  in  NUM_PROP*NUM_TAP  automata report taps, property p at [p*NUM_TAP +: NUM_TAP]
- clr_mask  in  NUM_PROP  one-cycle clear of sticky flag and counter per property
- viol  out  NUM_PROP  registered per-property violation, this cycle
- sticky  out  NUM_PROP  sticky violation flags
- any_viol  out  1  OR of viol
- cnt  out  NUM_PROP*CNT_W  saturating hit counters, property p at [p*CNT_W +: CNT_W]
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_id  out  ID_W  property index of head record
- rec_tstamp  out  TS_W  timestamp of head record

## Operation
- hit[p] = run & |taps[p]; viol[p] <= hit[p] every cycle.
- sticky[p] <= 1 on hit[p]; cleared by clr_mask[p]; hit wins over clear.
- cnt[p] increments on hit[p], saturates at 2^CNT_W-1; clr_mask[p] loads 0, or 1 if hit[p] same cycle.
- Timestamp counter ts: increments each cycle run=1, wraps to 0, holds when run=0.
- New violation: rise[p] = hit[p] & ~viol[p]. On rise, pend[p] <= 1 and pend_ts[p] <= ts (current value). A rise while pend[p]=1 is coalesced: pend_ts[p] keeps the older value.
- Arbiter: each cycle, lowest-index p with pend[p]=1 is written to the FIFO as {p, pend_ts[p]} if the FIFO can accept. pend[p] is cleared that cycle, unless a new rise on p occurs the same cycle, in which case pend[p] stays 1 with the new ts.
- FIFO accepts when not full, or when full and a pop happens the same cycle. When full with no pop, pend bits hold. No record is ever dropped.
- Pop when rec_valid & rec_ready. rec_id/rec_tstamp are stable while rec_valid=1 and rec_ready=0.
- clr_mask does not affect pend or the FIFO.
- Reset mid-operation: all state, including the FIFO and pend, is cleared immediately. Records in flight are discarded.

## Timing
- Reset values: viol=0, sticky=0, any_viol=0, cnt=0, rec_valid=0, rec_id=0, rec_tstamp=0, ts=0, pend=0, FIFO empty.
- Taps asserted in cycle T: viol, sticky, cnt, any_viol update at T+1. pend is set at T+1. With an empty FIFO and no higher-priority pend, rec_valid=1 at T+2 carrying ts value of cycle T.
- Throughput: one record per cycle sustained with rec_ready=1.
- k simultaneous rises: records emerge in ascending property index, one per cycle.

## Configuration
- LTL_AGG_TSTAMP_EN defined: ts counter, pend_ts storage and FIFO timestamp field present; behaviour as above.
- Not defined: none of that logic exists; rec_tstamp is tied to 0, FIFO stores rec_id only. All other behaviour is unchanged.

## Test plan
- Reset then idle 10 cycles: all outputs 0, rec_valid=0.
- run=1, taps[p3 tap2] high for cycle ts=5 only, rec_ready=1: viol[3] one cycle; sticky[3]=1, cnt[3]=1; one record id=3 tstamp=5, two cycles after the tap.
- Props 7, 1, 4 rise in the same cycle at ts=20: records in order id 1, 4, 7, all tstamp=20, consecutive cycles.
- rec_ready=0, FIFO_DEPTH=4, 6 distinct rises: FIFO holds 4 with rec_valid stable, 2 held in pend. Release rec_ready: all 6 delivered, none lost.
- CNT_W=4, hold taps[0] 20 cycles: cnt[0] saturates at 15. clr_mask[0] with tap high gives cnt=1 and sticky=1. clr_mask[0] with tap low gives cnt=0 and sticky=0.
- Assert reset with 3 records queued: rec_valid=0 immediately; after release, no stale records and ts restarts at 0.
